bytewrite_bram_ctrl: RTL

Request/response controller that fronts a one-cycle-latency byte-write block RAM. It accepts read and byte-masked write requests over a valid/ready interface and drives the RAM's write-enable, address and data pins. It captures the RAM read data one cycle later and returns it through a small response buffer with its own valid/ready handshake. It sits between a bus adapter (or debug/loader engine) and the byte-write BRAM on the FPGA builds.

---
 rtl/bytewrite_bram_pkg.sv | 16 +
 rtl/bram_resp_fifo.sv | 58 +++++
 rtl/bytewrite_bram_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/bytewrite_bram_pkg.sv
// Shared types for the byte-write BRAM controller: response entry layout and
// occupancy-counter sizing. The response data field is sized for the default 32-bit word.
package bytewrite_bram_pkg;

  localparam int unsigned BRAM_DW = 32;

  typedef struct packed {
    logic               write;
    logic [BRAM_DW-1:0] data;
  } resp_entry_t;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Response buffer for bytewrite_bram_ctrl: synchronous FIFO of DEPTH entries
// (any DEPTH >= 2) with head-entry outputs and an occupancy count.
module bram_resp_fifo
  import bytewrite_bram_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned OCC_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  resp_entry_t      i_entry,
  input  logic             i_pop,
  output resp_entry_t      o_head,
  output logic [OCC_W-1:0] o_occ
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  resp_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = i_pop & (r_occ != '0);
  assign w_do_push = i_push & ((r_occ != OCC_W'(DEPTH)) | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/bytewrite_bram_ctrl.sv
// Valid/ready front end for a one-cycle-latency byte-write BRAM with a credited
// response buffer. Define BYTEWRITE_BRAM_CTRL_WRITE_ACK_EN to make writes return a
// response; otherwise writes are posted. NB_COL*COL_WIDTH must equal BRAM_DW.
module bytewrite_bram_ctrl
  import bytewrite_bram_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 10,
  parameter  int unsigned COL_WIDTH  = 8,
  parameter  int unsigned NB_COL     = 4,
  parameter  int unsigned RESP_DEPTH = 3,
  localparam int unsigned DW         = NB_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_v_i,
  output logic                  req_ready_o,
  input  logic [NB_COL-1:0]     req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DW-1:0]         req_data_i,
  output logic                  resp_v_o,
  input  logic                  resp_ready_i,
  output logic                  resp_write_o,
  output logic [DW-1:0]         resp_data_o,
  output logic [NB_COL-1:0]     mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DW-1:0]         mem_data_o,
  input  logic [DW-1:0]         mem_data_i
);

  localparam int unsigned OCC_W = occ_width(RESP_DEPTH);
  localparam int unsigned CNT_W = OCC_W + 1;

  logic             w_acc;
  logic             w_is_wr;
  logic             w_need_resp;
  logic             w_credit_ok;
  logic [OCC_W-1:0] w_occ;
  logic             r_inflight;
  logic             r_inflight_wr;
  resp_entry_t      w_push_entry;
  resp_entry_t      w_head;

  assign w_is_wr = |req_we_i;

  // Credits count buffered plus in-flight responses; both are registered, so
  // resp_ready_i never reaches req_ready_o combinationally.
  assign w_credit_ok = ({1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight}) < CNT_W'(RESP_DEPTH);

`ifdef BYTEWRITE_BRAM_CTRL_WRITE_ACK_EN
  assign w_need_resp = 1'b1;
  assign req_ready_o = reset_n & w_credit_ok;
`else
  assign w_need_resp = ~w_is_wr;
  assign req_ready_o = reset_n & (w_is_wr | w_credit_ok);
`endif

  assign w_acc      = req_v_i & req_ready_o;
  assign mem_we_o   = w_acc ? req_we_i : '0;
  assign mem_addr_o = req_addr_i;
  assign mem_data_o = req_data_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight    <= 1'b0;
      r_inflight_wr <= 1'b0;
    end else begin
      r_inflight    <= w_acc & w_need_resp;
      r_inflight_wr <= w_acc & w_need_resp & w_is_wr;
    end
  end

  // RAM read data lands the cycle after acceptance and is buffered right away.
  assign w_push_entry = '{write: r_inflight_wr, data: mem_data_i};

  bram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .OCC_W (OCC_W)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (r_inflight),
    .i_entry (w_push_entry),
    .i_pop   (resp_ready_i),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

  assign resp_v_o     = (w_occ != '0);
  assign resp_data_o  = w_head.data;
  assign resp_write_o = w_head.write;

endmodule
